hazard_stall_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage datapath. It drives the write-enable and flush controls of the PC, the fetch-to-decode register and the decode-to-execute register. It detects load-use hazards and taken branches, and sequences multi-cycle execute operations (mult/div) by freezing the front of the pipeline for a fixed latency. It sits beside the pipeline registers and is fed by decode- and execute-stage fields.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_stall_ctrl_if.sv | 25 ++
 rtl/hazard_stall_ctrl_counter.sv | 20 ++
 rtl/hazard_stall_ctrl.sv | 88 ++++++++
 tb/tb_hazard_stall_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding and control-bundle defaults for hazard_stall_ctrl
package hazard_pkg;
  typedef enum logic [1:0] {RUN, MC_WAIT, MC_DONE} hz_state_t;
  localparam int REG_ZERO = 0;
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic ex_hold;
    logic exmem_bubble;
  } hz_ctl_t;
  localparam hz_ctl_t CTL_IDLE   = hz_ctl_t'(6'b110000);
  localparam hz_ctl_t CTL_FREEZE = hz_ctl_t'(6'b000011);
  localparam hz_ctl_t CTL_LU     = hz_ctl_t'(6'b000100);
  localparam hz_ctl_t CTL_BRANCH = hz_ctl_t'(6'b111100);
  localparam hz_ctl_t CTL_RESET  = hz_ctl_t'(6'b001101);
endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: decode/execute hazard fields in, pipeline-register controls out
interface hazard_stall_ctrl_if #(parameter int REG_W = 5);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rt;
  logic             ex_branch_taken;
  logic             ex_mc_start;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             ex_hold;
  logic             exmem_bubble;
  logic             mc_busy;
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken, ex_mc_start,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, exmem_bubble, mc_busy
  );
  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken, ex_mc_start,
    output pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, exmem_bubble, mc_busy
  );
endinterface

// File: rtl/hazard_stall_ctrl_counter.sv
// mc_stall_counter: loadable down-counter timing the multi-cycle freeze; last flags cnt==1
module mc_stall_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         last
);
  logic [W-1:0] cnt_q, cnt_d;
  // load wins over decrement; otherwise hold
  always_comb cnt_d = load ? load_val : dec ? cnt_q - W'(1) : cnt_q;
  // counter register, cleared by reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  assign last = cnt_q == W'(1);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use / branch / multi-cycle hazard control; HAZARD_CTRL_PERF_EN adds perf counters
module hazard_stall_ctrl #(
  parameter int MC_LAT = 4,
  parameter int REG_W  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_stall_ctrl_if.slave   bus
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]          perf_stall_cycles,
  output logic [31:0]          perf_flush_count
`endif
);
  import hazard_pkg::*;
  localparam int CW = $clog2(MC_LAT);
  hz_state_t state_q, state_d;
  hz_ctl_t   ctl;
  logic      lu, br_act, cnt_load, cnt_last, busy;
  assign lu = bus.ex_mem_read && bus.ex_rt != REG_W'(REG_ZERO) &&
              (bus.ex_rt == bus.id_rs || (bus.id_uses_rt && bus.ex_rt == bus.id_rt));
  assign br_act = bus.ex_branch_taken && state_q != MC_WAIT;
  mc_stall_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .dec      (state_q == MC_WAIT),
    .load_val (CW'(MC_LAT - 2)),
    .last     (cnt_last)
  );
  // next state and Mealy outputs: freeze > branch > multi-cycle start > load-use > idle
  always_comb begin
    ctl      = CTL_IDLE;
    state_d  = RUN;
    cnt_load = 1'b0;
    busy     = state_q == MC_WAIT;
    if (state_q == MC_WAIT) begin
      ctl     = CTL_FREEZE;
      state_d = cnt_last ? MC_DONE : MC_WAIT;
    end else if (br_act) begin
      ctl = CTL_BRANCH;
    end else if (bus.ex_mc_start && state_q == RUN) begin
      ctl      = CTL_FREEZE;
      cnt_load = MC_LAT > 2;
      state_d  = MC_LAT > 2 ? MC_WAIT : MC_DONE;
    end else if (lu) begin
      ctl = CTL_LU;
    end
    if (!rst_n) begin
      ctl  = CTL_RESET;
      busy = 1'b0;
    end
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  assign bus.pc_write     = ctl.pc_write;
  assign bus.ifid_write   = ctl.ifid_write;
  assign bus.ifid_flush   = ctl.ifid_flush;
  assign bus.idex_bubble  = ctl.idex_bubble;
  assign bus.ex_hold      = ctl.ex_hold;
  assign bus.exmem_bubble = ctl.exmem_bubble;
  assign bus.mc_busy      = busy;
  // a branch and a new multi-cycle op cannot both be resolved in EX at once
  always @(posedge clk)
    if (rst_n && state_q == RUN)
      br_mc_exclusive: assert (!(bus.ex_branch_taken && bus.ex_mc_start));
`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d, perf_flush_q, perf_flush_d;
  // stall cycles count any frozen PC; flushes count only branch-caused ones
  always_comb begin
    perf_stall_d = perf_stall_q + (ctl.pc_write ? 32'd0 : 32'd1);
    perf_flush_d = perf_flush_q + (br_act ? 32'd1 : 32'd0);
  end
  // counter registers, free-running modulo 2^32
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_count  = perf_flush_q;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: three controllers (MC_LAT 4, 2, 8) against a window-based reference model
module tb_hazard_stall_ctrl;
  localparam int LAT [3] = '{4, 2, 8};
  localparam logic [6:0] E_IDLE = 7'b1100000;
  localparam logic [6:0] E_LU   = 7'b0001000;
  localparam logic [6:0] E_BR   = 7'b1111000;
  localparam logic [6:0] E_FRZ  = 7'b0000110;
  localparam logic [6:0] E_RST  = 7'b0011010;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic id_uses_rt = 1'b0, ex_mem_read = 1'b0, ex_branch_taken = 1'b0, ex_mc_start = 1'b0;
  wire  [2:0][6:0] got;
  logic [2:0][6:0] exp_v;
  wire  [2:0][31:0] ps, pf;
  int ts [3] = '{-100, -100, -100};
  int cyc = 0;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_stall_ctrl_if #(.REG_W(5)) bi ();
    assign bi.id_rs = id_rs;
    assign bi.id_rt = id_rt;
    assign bi.id_uses_rt = id_uses_rt;
    assign bi.ex_mem_read = ex_mem_read;
    assign bi.ex_rt = ex_rt;
    assign bi.ex_branch_taken = ex_branch_taken;
    assign bi.ex_mc_start = ex_mc_start;
    assign got[g] = {bi.pc_write, bi.ifid_write, bi.ifid_flush, bi.idex_bubble,
                     bi.ex_hold, bi.exmem_bubble, bi.mc_busy};
`ifdef HAZARD_CTRL_PERF_EN
    hazard_stall_ctrl #(.MC_LAT(LAT[g]), .REG_W(5)) u (
      .clk(clk), .rst_n(rst_n), .bus(bi.slave),
      .perf_stall_cycles(ps[g]), .perf_flush_count(pf[g]));
`else
    hazard_stall_ctrl #(.MC_LAT(LAT[g]), .REG_W(5)) u (
      .clk(clk), .rst_n(rst_n), .bus(bi.slave));
    assign ps[g] = '0;
    assign pf[g] = '0;
`endif
  end
  // drive one cycle and compute expected outputs from the op windows:
  // op started at T freezes T..T+L-2, is busy T+1..T+L-2, and is done (start ignored) at T+L-1
  task automatic tick(input logic r, input logic [4:0] rs, rt, input logic urt, mr,
                      input logic [4:0] xrt, input logic br, mc);
    logic lu;
    int ph;
    @(negedge clk);
    rst_n = r; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    ex_mem_read = mr; ex_rt = xrt; ex_branch_taken = br; ex_mc_start = mc;
    #1;
    if (!r) begin
      for (int i = 0; i < 3; i++) begin
        exp_v[i] = E_RST;
        ts[i] = -100;
      end
      cyc = 0;
    end else begin
      lu = mr && xrt != 0 && (xrt == rs || (urt && xrt == rt));
      for (int i = 0; i < 3; i++) begin
        ph = cyc - ts[i];
        if (ph >= 1 && ph <= LAT[i] - 2) exp_v[i] = E_FRZ | 7'd1;
        else if (br) exp_v[i] = E_BR;
        else if (mc && ph != LAT[i] - 1) begin
          exp_v[i] = E_FRZ;
          ts[i] = cyc;
        end else if (lu) exp_v[i] = E_LU;
        else exp_v[i] = E_IDLE;
      end
      cyc++;
    end
  endtask
  task automatic test_reset;
    tick(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (got[i] !== exp_v[i]) begin n_bad++; $display("FAIL reset dut%0d got %b exp %b", i, got[i], exp_v[i]); end
    end
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (got[i] !== exp_v[i]) begin n_bad++; $display("FAIL reset_release dut%0d got %b exp %b", i, got[i], exp_v[i]); end
    end
  endtask
  task automatic test_load_use;
    logic [4:0] a [4] = '{5'd8, 5'd0, 5'd8, 5'd8};
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: tick(1, 8, 3, 1, 1, 8, 0, 0);
        1: tick(1, 0, 0, 1, 1, 0, 0, 0);
        2: tick(1, 1, 8, 0, 1, 8, 0, 0);
        default: tick(1, 1, 8, 1, 1, a[k], 0, 0);
      endcase
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (got[i] !== exp_v[i]) begin n_bad++; $display("FAIL load_use%0d dut%0d got %b exp %b", k, i, got[i], exp_v[i]); end
      end
      tick(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (got[i] !== E_IDLE) begin n_bad++; $display("FAIL load_use_clear%0d dut%0d got %b exp %b", k, i, got[i], E_IDLE); end
      end
    end
  endtask
  task automatic test_branch;
    tick(1, 8, 0, 0, 1, 8, 1, 0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (got[i] !== E_BR) begin n_bad++; $display("FAIL branch_over_lu dut%0d got %b exp %b", i, got[i], E_BR); end
    end
  endtask
  task automatic test_multicycle;
    for (int c = 0; c < 16; c++) begin
      tick(1, 0, 0, 0, 0, 0, 0, c < 6);
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (got[i] !== exp_v[i]) begin n_bad++; $display("FAIL mc_c%0d dut%0d got %b exp %b", c, i, got[i], exp_v[i]); end
      end
    end
  endtask
  task automatic test_reset_mid_op;
    tick(1, 0, 0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (got[2][0] !== 1'b0) begin n_bad++; $display("FAIL reset_mid_busy got %b exp 0", got[2][0]); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (got[i] !== E_RST) begin n_bad++; $display("FAIL reset_mid dut%0d got %b exp %b", i, got[i], E_RST); end
    end
    for (int c = 0; c < 3; c++) begin
      tick(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (got[i] !== E_IDLE) begin n_bad++; $display("FAIL reset_mid_idle%0d dut%0d got %b exp %b", c, i, got[i], E_IDLE); end
      end
    end
  endtask
  task automatic test_random;
    int sel;
    for (int c = 0; c < 400; c++) begin
      sel = int'($urandom_range(0, 15));
      tick(1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
           1'($urandom), 5'($urandom_range(0, 3)), sel == 0, sel == 1);
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (got[i] !== exp_v[i]) begin n_bad++; $display("FAIL random_c%0d dut%0d got %b exp %b", c, i, got[i], exp_v[i]); end
      end
    end
  endtask
`ifdef HAZARD_CTRL_PERF_EN
  task automatic test_perf;
    tick(0, 0, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    tick(1, 8, 0, 0, 1, 8, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0, 1);
    repeat (4) tick(1, 0, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 1, 0);
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 1, 0);
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (ps[0] !== 32'd4) begin n_bad++; $display("FAIL perf_stall got %0d exp 4", ps[0]); end
    n_cmp++;
    if (pf[0] !== 32'd2) begin n_bad++; $display("FAIL perf_flush got %0d exp 2", pf[0]); end
  endtask
`endif
  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_multicycle();
    test_reset_mid_op();
    test_random();
`ifdef HAZARD_CTRL_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
